fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 4'hF, instr[15:12] value that halts fetch.
REQ-003 Parameter NOP_INSTR, default 16'h0000, bubble encoding driven on if_instr_out.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall_n  input  1  active-low hold from hazard unit; same signal that gates the IF/ID register.
REQ-007 branch_taken  input  1  redirect request from a later stage.
REQ-008 branch_target  input  16  redirect PC, valid when branch_taken=1.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  16  instruction memory address, held stable while imem_req=1 and imem_ready=0.
REQ-011 imem_rdata  input  16  instruction word, valid when imem_ready=1.
REQ-012 imem_ready  input  1  access completes in the cycle imem_req=1 and imem_ready=1.
REQ-013 if_instr_out  output  16  fetched instruction to IF/ID.
REQ-014 if_pc_out  output  16  address of if_instr_out plus 2, to IF/ID.
REQ-015 if_flush_out  output  1  1 = if_instr_out is a bubble, to IF/ID flush input.
REQ-016 halted  output  1  1 while in HALT state.

Function
REQ-017 The unit SHALL hold registers pc, req_addr, state {FETCH, DISCARD, HALT}, a one-entry hold buffer (hold_instr, hold_pc, hold_valid), and registered outputs.
REQ-018 imem_req SHALL be 1 in DISCARD and in FETCH when hold_valid=0; 0 otherwise; imem_addr SHALL equal req_addr.
REQ-019 In FETCH with no request outstanding, req_addr SHALL equal pc; once issued, req_addr SHALL not change until completion.
REQ-020 Completion in FETCH with stall_n=1: if_instr_out<=imem_rdata, if_pc_out<=req_addr+2, if_flush_out<=0, pc<=req_addr+2 (wraps mod 2^16, 16'hFFFE+2=16'h0000).
REQ-021 Completion in FETCH with stall_n=0: hold_instr<=imem_rdata, hold_pc<=req_addr+2, hold_valid<=1, pc<=req_addr+2; outputs unchanged.
REQ-022 Any cycle with stall_n=0: if_instr_out, if_pc_out, if_flush_out SHALL hold their values.
REQ-023 stall_n=1 with hold_valid=1: outputs<=hold buffer with if_flush_out<=0, hold_valid<=0; request resumes next cycle.
REQ-024 FETCH, stall_n=1, no completion, no hold: if_instr_out<=NOP_INSTR, if_flush_out<=1, if_pc_out unchanged.
REQ-025 Completed word with [15:12]=HALT_OPCODE SHALL be delivered normally (directly or via hold buffer), pc SHALL stay at its address (not +2), state<=HALT.
REQ-026 HALT: imem_req=0, halted=1; after the halt word is delivered, outputs become bubbles whenever stall_n=1.
REQ-027 branch_taken=1 SHALL take priority over stall, completion and halt: pc<=branch_target, req_addr<=branch_target if no access outstanding, hold_valid<=0, if_instr_out<=NOP_INSTR, if_flush_out<=1 (even with stall_n=0).
REQ-028 branch_taken with an access outstanding and not completing this cycle: state<=DISCARD; in DISCARD completion data SHALL be dropped, then req_addr<=pc, state<=FETCH.
REQ-029 branch_taken in the same cycle as a completion: completing data dropped, state<=FETCH, req_addr<=branch_target.
REQ-030 branch_taken in HALT: state<=FETCH at branch_target, halted<=0.
REQ-031 With imem_ready tied 1 and stall_n=1, throughput SHALL be one instruction per cycle, latency one cycle from request to if_instr_out.

Reset
REQ-032 While rst_n=0 (asynchronously): pc=req_addr=RESET_PC, state=FETCH, hold_valid=0, if_instr_out=NOP_INSTR, if_pc_out=RESET_PC, if_flush_out=1, halted=0.
REQ-033 imem_req SHALL be 0 while rst_n=0 and 1 in the first cycle after release, addressing RESET_PC.
REQ-034 Reset mid-access SHALL abandon the access; no completion data from before reset is delivered.

Verification
REQ-035 imem_ready=1, rdata=addr-derived, stall_n=1 -> words from 0x0000,0x0002,0x0004 on consecutive cycles, if_pc_out 0x0002,0x0004,0x0006, flush 0.
REQ-036 imem_ready low 3 cycles per access -> 3 bubbles (NOP_INSTR, flush 1) between words, imem_addr stable throughout.
REQ-037 stall_n=0 for 2 cycles as access completes -> outputs frozen, word delivered from hold buffer cycle after stall_n=1, no refetch.
REQ-038 branch_taken target 0x0100 while access to 0x0006 outstanding -> DISCARD, 0x0006 data dropped, next request 0x0100, flush 1 meanwhile.
REQ-039 fetch 0xF000 at 0x0010 -> delivered with if_pc_out 0x0012, halted=1, imem_req=0; branch_taken target 0x0020 -> fetch resumes at 0x0020.
REQ-040 rst_n pulsed low mid-access at 0x0008 -> all reset values immediately, first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives instruction memory requests, absorbs stalls in a
// one-entry hold buffer, drops in-flight data after a redirect, and stops on a halt word.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_n,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] if_instr_out,
    output logic [15:0] if_pc_out,
    output logic        if_flush_out,
    output logic        halted
);

    typedef enum logic [1:0] {StFetch, StDiscard, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] hold_pc_q, hold_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] out_pc_q, out_pc_d;
    logic        flush_q, flush_d;

    logic        req_active;
    logic        done;
    logic        is_halt;
    logic [15:0] next_addr;
    logic [15:0] fetched_pc;

    // A request is live while discarding or while fetching with an empty hold buffer.
    assign req_active = (state_q == StDiscard) || ((state_q == StFetch) && !hold_valid_q);
    // Gate with rst_n so no request is visible while reset is asserted.
    assign imem_req   = rst_n & req_active;
    assign imem_addr  = req_addr_q;
    assign done       = req_active & imem_ready;
    assign is_halt    = (imem_rdata[15:12] == HALT_OPCODE);
    assign next_addr  = req_addr_q + 16'd2;
    assign fetched_pc = is_halt ? req_addr_q : next_addr;

    assign if_instr_out = instr_q;
    assign if_pc_out    = out_pc_q;
    assign if_flush_out = flush_q;
    assign halted       = (state_q == StHalt);

    // Next-state logic: redirect first, then discard, hold-buffer drain, completion, bubble.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;
        instr_d      = instr_q;
        out_pc_d     = out_pc_q;
        flush_d      = flush_q;

        if (branch_taken) begin
            pc_d         = branch_target;
            hold_valid_d = 1'b0;
            instr_d      = NOP_INSTR;
            flush_d      = 1'b1;
            if (req_active && !imem_ready) begin
                // Access still in flight: its data must be thrown away when it arrives.
                state_d = StDiscard;
            end else begin
                state_d    = StFetch;
                req_addr_d = branch_target;
            end
        end else begin
            case (state_q)
                StDiscard: begin
                    if (stall_n) begin
                        instr_d = NOP_INSTR;
                        flush_d = 1'b1;
                    end
                    if (imem_ready) begin
                        req_addr_d = pc_q;
                        state_d    = StFetch;
                    end
                end
                default: begin
                    if (hold_valid_q) begin
                        if (stall_n) begin
                            instr_d      = hold_instr_q;
                            out_pc_d     = hold_pc_q;
                            flush_d      = 1'b0;
                            hold_valid_d = 1'b0;
                        end
                    end else if (done) begin
                        // A halt word keeps pc on its own address.
                        pc_d       = fetched_pc;
                        req_addr_d = fetched_pc;
                        if (is_halt) begin
                            state_d = StHalt;
                        end
                        if (stall_n) begin
                            instr_d  = imem_rdata;
                            out_pc_d = next_addr;
                            flush_d  = 1'b0;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = next_addr;
                            hold_valid_d = 1'b1;
                        end
                    end else if (stall_n) begin
                        instr_d = NOP_INSTR;
                        flush_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= RESET_PC;
            hold_valid_q <= 1'b0;
            instr_q      <= NOP_INSTR;
            out_pc_q     <= RESET_PC;
            flush_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
            instr_q      <= instr_d;
            out_pc_q     <= out_pc_d;
            flush_q      <= flush_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized
// stimulus, all checked every cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0000;
    localparam int ModeFetch   = 0;
    localparam int ModeDiscard = 1;
    localparam int ModeHalt    = 2;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_n = 1'b1;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] if_instr_out;
    logic [15:0] if_pc_out;
    logic        if_flush_out;
    logic        halted;
    logic [15:0] halt_addr = 16'h0010;

    int tests = 0;
    int fails = 0;

    // Literal expectations for the next compare, set by the directed sequence.
    logic        lit_en = 1'b0;
    logic [15:0] lit_instr, lit_pc, lit_addr;
    logic        lit_flush, lit_req, lit_halted;

    // Model state.
    entry_t      m_hold[$];
    entry_t      m_e;
    logic [15:0] m_pc, m_fetch, m_instr, m_opc, m_w;
    logic        m_flush, m_req, m_done, exp_req;
    int          m_mode;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_n      (stall_n),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .if_instr_out (if_instr_out),
        .if_pc_out    (if_pc_out),
        .if_flush_out (if_flush_out),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Memory contents derived from the address; one address holds the halt word.
    function automatic logic [15:0] word_at(input logic [15:0] a, input logic [15:0] ha);
        logic [15:0] w;
        w = a ^ 16'h3C5A;
        if (w[15:12] == 4'hF) w[15:12] = 4'h7;
        if (a == ha) w = 16'hF000;
        return w;
    endfunction

    assign imem_rdata = word_at(imem_addr, halt_addr);

    // Behavioural model, advanced on each rising edge (reset asynchronously).
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pc = 16'h0000; m_fetch = 16'h0000; m_mode = ModeFetch;
            m_hold.delete();
            m_instr = NOP; m_opc = 16'h0000; m_flush = 1'b1;
        end else begin
            m_req  = (m_mode == ModeDiscard) || (m_mode == ModeFetch && m_hold.size() == 0);
            m_done = m_req && imem_ready;
            if (branch_taken) begin
                m_instr = NOP; m_flush = 1'b1; m_hold.delete(); m_pc = branch_target;
                if (m_req && !m_done) m_mode = ModeDiscard;
                else begin m_mode = ModeFetch; m_fetch = branch_target; end
            end else if (m_mode == ModeDiscard) begin
                if (stall_n) begin m_instr = NOP; m_flush = 1'b1; end
                if (m_done) begin m_fetch = m_pc; m_mode = ModeFetch; end
            end else if (m_hold.size() != 0) begin
                if (stall_n) begin
                    m_e = m_hold.pop_front();
                    m_instr = m_e.instr; m_opc = m_e.pc; m_flush = 1'b0;
                end
            end else if (m_done) begin
                m_w = word_at(m_fetch, halt_addr);
                m_e.instr = m_w;
                m_e.pc = m_fetch + 16'd2;
                if (m_w[15:12] == 4'hF) m_mode = ModeHalt;
                else m_fetch = m_fetch + 16'd2;
                m_pc = m_fetch;
                if (stall_n) begin m_instr = m_e.instr; m_opc = m_e.pc; m_flush = 1'b0; end
                else m_hold.push_back(m_e);
            end else if (stall_n) begin
                m_instr = NOP; m_flush = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model every cycle, plus literal pins when set.
    initial forever begin
        @(negedge clk or negedge rst_n);
        #1;
        exp_req = rst_n && ((m_mode == ModeDiscard) || (m_mode == ModeFetch && m_hold.size() == 0));
        chk("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
        chk("imem_addr", imem_addr, m_fetch);
        chk("if_instr_out", if_instr_out, m_instr);
        chk("if_pc_out", if_pc_out, m_opc);
        chk("if_flush_out", {15'd0, if_flush_out}, {15'd0, m_flush});
        chk("halted", {15'd0, halted}, {15'd0, m_mode == ModeHalt});
        if (lit_en) begin
            chk("lit_instr", if_instr_out, lit_instr);
            chk("lit_pc", if_pc_out, lit_pc);
            chk("lit_flush", {15'd0, if_flush_out}, {15'd0, lit_flush});
            chk("lit_req", {15'd0, imem_req}, {15'd0, lit_req});
            chk("lit_addr", imem_addr, lit_addr);
            chk("lit_halted", {15'd0, halted}, {15'd0, lit_halted});
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic rdy, input logic br,
                       input logic [15:0] tgt);
        @(negedge clk);
        #2;
        lit_en = 1'b0;
        stall_n = st; imem_ready = rdy; branch_taken = br; branch_target = tgt;
        rst_n = rst;
    endtask

    task automatic expect_out(input logic [15:0] instr, input logic [15:0] pc, input logic flush,
                              input logic req, input logic [15:0] addr, input logic hlt);
        lit_instr = instr; lit_pc = pc; lit_flush = flush;
        lit_req = req; lit_addr = addr; lit_halted = hlt;
        lit_en = 1'b1;
    endtask

    initial begin
        expect_out(NOP, 16'h0000, 1, 0, 16'h0000, 0);
        cyc(0, 1, 1, 0, 0);
        // Release: first request addresses the reset PC.
        cyc(1, 1, 0, 0, 0);          expect_out(NOP, 16'h0000, 1, 1, 16'h0000, 0);
        // Zero-wait streaming.
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3C5A, 16'h0002, 0, 1, 16'h0002, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3C58, 16'h0004, 0, 1, 16'h0004, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3C5E, 16'h0006, 0, 1, 16'h0006, 0);
        // Wait states give bubbles with a stable address.
        repeat (3) begin
            cyc(1, 1, 0, 0, 0);      expect_out(NOP, 16'h0006, 1, 1, 16'h0006, 0);
        end
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3C5C, 16'h0008, 0, 1, 16'h0008, 0);
        // Stall as the access completes: frozen outputs, delivery from the hold buffer.
        cyc(1, 0, 1, 0, 0);          expect_out(16'h3C5C, 16'h0008, 0, 0, 16'h000A, 0);
        cyc(1, 0, 1, 0, 0);          expect_out(16'h3C5C, 16'h0008, 0, 0, 16'h000A, 0);
        cyc(1, 1, 0, 0, 0);          expect_out(16'h3C52, 16'h000A, 0, 1, 16'h000A, 0);
        // Redirect with an access outstanding: discard, then fetch the target.
        cyc(1, 1, 0, 1, 16'h0100);   expect_out(NOP, 16'h000A, 1, 1, 16'h000A, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(NOP, 16'h000A, 1, 1, 16'h0100, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3D5A, 16'h0102, 0, 1, 16'h0102, 0);
        // Redirect on a completing access, then run into the halt word.
        cyc(1, 1, 1, 1, 16'h000E);   expect_out(NOP, 16'h0102, 1, 1, 16'h000E, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3C54, 16'h0010, 0, 1, 16'h0010, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'hF000, 16'h0012, 0, 0, 16'h0010, 1);
        cyc(1, 1, 1, 0, 0);          expect_out(NOP, 16'h0012, 1, 0, 16'h0010, 1);
        cyc(1, 1, 1, 1, 16'h0020);   expect_out(NOP, 16'h0012, 1, 1, 16'h0020, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3C7A, 16'h0022, 0, 1, 16'h0022, 0);
        // PC wrap past the top of the address space.
        cyc(1, 1, 1, 1, 16'hFFFE);   expect_out(NOP, 16'h0022, 1, 1, 16'hFFFE, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'hC3A4, 16'h0000, 0, 1, 16'h0000, 0);
        // Reset in the middle of an access to 0x0008.
        cyc(1, 1, 1, 1, 16'h0008);   expect_out(NOP, 16'h0000, 1, 1, 16'h0008, 0);
        cyc(1, 1, 0, 0, 0);          expect_out(NOP, 16'h0000, 1, 1, 16'h0008, 0);
        cyc(0, 1, 1, 0, 0);          expect_out(NOP, 16'h0000, 1, 0, 16'h0000, 0);
        cyc(1, 1, 0, 0, 0);          expect_out(NOP, 16'h0000, 1, 1, 16'h0000, 0);
        cyc(1, 1, 1, 0, 0);          expect_out(16'h3C5A, 16'h0002, 0, 1, 16'h0002, 0);

        // Randomized traffic; targets stay low so the halt word is reached now and then.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom % 400) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                ($urandom % 16) == 0, 16'({$urandom_range(0, 31), 1'b0}));
        end
        cyc(1, 1, 1, 0, 0);
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
